irq_src_ctrl: RTL and testbench
===============================

Name: irq_src_ctrl

Overview:
- Sub-CPU interrupt source controller for the MCD mapper. It sits in front of irq_ctrl and drives that block's ireq[6:1] and imsk[6:1] inputs.
- Owns the IMASK register and the 8-bit interval timer (level 3).
- Converts single-cycle event strobes from the graphics, main-CPU, CDD, CDC and subcode logic into clean, spaced request pulses. irq_ctrl's 2-stage edge detector catches every one of those pulses.

Parameters:
PRESC_DIV, 1536, clk_asic cycles per timer tick (30.72 us at 50 MHz); range 2..2047
PULSE_LEN, 4, clk_asic cycles each ireq pulse is held high; range 2..15
GAP_LEN, 4, minimum clk_asic cycles ireq is held low after a pulse; range 2..15

Ports:
clk_asic  in  1  ASIC clock; all flops update on negedge, same as irq_ctrl
rst_n  in  1  synchronous reset, active-low
reg_we  in  1  register write strobe, one cycle
reg_sel  in  1  register select: 0 = TIMER, 1 = IMASK
reg_din  in  8  write data
reg_dout  out  8  read data, combinational from reg_sel
evt  in  [6:1]  event strobes, one cycle each, bit index = IRQ level; evt[3] ignored
ireq  out  [6:1]  stretched request pulses to irq_ctrl
imsk  out  [6:1]  IMASK[6:1] to irq_ctrl

Behaviour:
- Reset (rst_n=0 at a negedge) clears the following, regardless of any other input that cycle:
  - ireq=0, imsk=0
  - TIMER reload=0, timer count=0, prescaler=0
  - all stretch state machines to IDLE, all pend latches=0
- Reset during an active pulse truncates it immediately.
- Register reads:
  - reg_sel=0: reg_dout = TIMER reload value.
  - reg_sel=1: reg_dout = {1'b0, IMASK[6:1], 1'b0}.
- IMASK write: IMASK <= reg_din[6:1] at the write edge; imsk follows in the same cycle. reg_din[7] and reg_din[0] are ignored.
- TIMER write: reload <= reg_din, count <= reg_din, prescaler <= 0.
- Prescaler:
  - Counts 0..PRESC_DIV-1 every clk_asic cycle, but only while reload != 0.
  - Held at 0 while reload == 0.
  - tick = (prescaler == PRESC_DIV-1).
- Timer on each tick with reload != 0:
  - If count == 0: raise internal event e3 for one cycle and set count <= reload.
  - Otherwise count <= count-1.
  - The IRQ3 period is therefore (reload+1) ticks after the first expiry. The first expiry occurs reload+1 ticks after the write.
- Write/tick collision: if a TIMER write and a tick occur in the same cycle, the write wins and no e3 is raised.
- Writing 0 to TIMER stops the timer. Any in-flight level-3 pulse still completes.
- Event vector: e[6:1] = {evt[6:4], e3, evt[2:1]}.
- Each level n has one independent stretch FSM with states IDLE, HIGH and GAP, a 4-bit counter and a 1-bit pend latch:
  - IDLE: on e[n], go to HIGH and drive ireq[n]=1 from the next cycle.
  - HIGH: ireq[n]=1 for exactly PULSE_LEN cycles, then go to GAP.
  - GAP: ireq[n]=0 for exactly GAP_LEN cycles. At the end of GAP, if pend=1, clear pend and go straight to HIGH; otherwise go to IDLE.
  - An e[n] arriving in HIGH or GAP sets pend. Multiple events coalesce into one pending pulse.
  - An e[n] on the same cycle that a GAP expires with pend=1 is absorbed into that pulse.
- Masking is applied downstream in irq_ctrl; this block emits pulses regardless of IMASK.
- Clearing IMASK bit n by a write clears pend[n] on that edge. The in-flight HIGH/GAP sequence runs to completion; no new pulse follows it.
- A simultaneous e[n] and clear of IMASK bit n leaves pend[n]=0.
- Latency: e[n] in IDLE → ireq[n] high on the next negedge. Minimum spacing between consecutive pulse starts is PULSE_LEN+GAP_LEN cycles.
- Width rules: timer count is 8 bits, never wraps below 0 (reload takes over at 0). Prescaler is 11 bits. Stretch counters are 4 bits.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with evt=6'h3F, then release → ireq=0, imsk=0, reg_dout=0 for both selects.
- Timer: PRESC_DIV=8; write TIMER=2 → ireq[3] rises after 3 ticks (24 cycles) and every 24 cycles thereafter, high exactly 4 cycles each. Write TIMER=0 → no further ireq[3] pulses.
- Event stretch and queue:
  - evt[5] at cycle 0 → ireq[5] high cycles 1..4, low cycles 5..8.
  - evt[5] pulses at cycles 2 and 6 → a single second pulse, high cycles 9..12.
- Mask drop: IMASK=0x7E; evt[4] at cycle 0 and again at cycle 2; write IMASK=0x6E at cycle 3 → exactly one ireq[4] pulse (cycles 1..4); imsk=6'b110111 from cycle 3.
- Collision: TIMER write of 5 on the same cycle as a tick with count=0 → no ireq[3] pulse; count=5; prescaler restarts from 0.
- Readback: write IMASK=0xFF → reg_dout=0x7E with reg_sel=1. Write TIMER=0xA5 → reg_dout=0xA5 with reg_sel=0. evt[3] pulses produce no ireq[3].

Source files
------------

// File: rtl/irq_src_ctrl.sv
// irq_src_ctrl: sub-CPU interrupt source controller for the MCD mapper.
// Owns IMASK and the level-3 interval timer. It also stretches single-cycle
// event strobes into spaced request pulses for irq_ctrl. Every flop updates
// on the falling edge of clk_asic, matching irq_ctrl.
module irq_src_ctrl #(
    parameter int PRESC_DIV = 1536,
    parameter int PULSE_LEN = 4,
    parameter int GAP_LEN   = 4
) (
    input  logic       clk_asic,
    input  logic       rst_n,
    input  logic       reg_we,
    input  logic       reg_sel,
    input  logic [7:0] reg_din,
    output logic [7:0] reg_dout,
    input  logic [6:1] evt,
    output logic [6:1] ireq,
    output logic [6:1] imsk
);

    localparam logic [10:0] PRESC_LAST = 11'(PRESC_DIV - 1);
    localparam logic [3:0]  PULSE_LAST = 4'(PULSE_LEN - 1);
    localparam logic [3:0]  GAP_LAST   = 4'(GAP_LEN - 1);

    typedef enum logic [1:0] {IDLE, HIGH, GAP} st_t;

    logic [7:0]  reload_q;
    logic [7:0]  count_q;
    logic [10:0] presc_q;
    logic [6:1]  imask_q;
    st_t         st_q   [6:1];
    st_t         st_d   [6:1];
    logic [3:0]  cnt_q  [6:1];
    logic [3:0]  cnt_d  [6:1];
    logic [6:1]  pend_q;
    logic [6:1]  pend_d;

    logic        timer_wr;
    logic        mask_wr;
    logic        tick;
    logic        e3;
    logic [6:1]  ev;
    logic [6:1]  clr;

    assign timer_wr = reg_we & ~reg_sel;
    assign mask_wr  = reg_we & reg_sel;
    assign tick     = (reload_q != 8'd0) && (presc_q == PRESC_LAST);
    // A TIMER write landing on a tick wins, so the expiry is dropped.
    assign e3       = tick && (count_q == 8'd0) && !timer_wr;
    assign ev       = {evt[6:4], e3, evt[2:1]};
    // Only bits going 1 -> 0 count as a clear; they cancel any pending pulse.
    assign clr      = mask_wr ? (imask_q & ~reg_din[6:1]) : 6'd0;

    assign imsk     = imask_q;
    assign reg_dout = reg_sel ? {1'b0, imask_q, 1'b0} : reload_q;

    // Prescaler and interval timer; a zero reload parks both counters.
    always_ff @(negedge clk_asic) begin
        if (!rst_n) begin
            reload_q <= 8'd0;
            count_q  <= 8'd0;
            presc_q  <= 11'd0;
        end else if (timer_wr) begin
            reload_q <= reg_din;
            count_q  <= reg_din;
            presc_q  <= 11'd0;
        end else if (reload_q == 8'd0) begin
            presc_q  <= 11'd0;
        end else begin
            presc_q <= tick ? 11'd0 : presc_q + 11'd1;
            if (tick) begin
                count_q <= (count_q == 8'd0) ? reload_q : count_q - 8'd1;
            end
        end
    end

    // IMASK register.
    always_ff @(negedge clk_asic) begin
        if (!rst_n) begin
            imask_q <= 6'd0;
        end else if (mask_wr) begin
            imask_q <= reg_din[6:1];
        end
    end

    // Stretch FSM state registers, one per level.
    always_ff @(negedge clk_asic) begin
        if (!rst_n) begin
            for (int n = 1; n <= 6; n++) begin
                st_q[n]  <= IDLE;
                cnt_q[n] <= 4'd0;
            end
            pend_q <= 6'd0;
        end else begin
            for (int n = 1; n <= 6; n++) begin
                st_q[n]  <= st_d[n];
                cnt_q[n] <= cnt_d[n];
            end
            pend_q <= pend_d;
        end
    end

    // Stretch FSM next state: IDLE -> HIGH (PULSE_LEN) -> GAP (GAP_LEN) -> IDLE/HIGH.
    always_comb begin
        pend_d = pend_q;
        for (int n = 1; n <= 6; n++) begin
            st_d[n]  = st_q[n];
            cnt_d[n] = cnt_q[n];
            case (st_q[n])
                IDLE: begin
                    pend_d[n] = 1'b0;
                    if (ev[n]) begin
                        st_d[n]  = HIGH;
                        cnt_d[n] = 4'd0;
                    end
                end
                HIGH: begin
                    pend_d[n] = (pend_q[n] | ev[n]) & ~clr[n];
                    if (cnt_q[n] == PULSE_LAST) begin
                        st_d[n]  = GAP;
                        cnt_d[n] = 4'd0;
                    end else begin
                        cnt_d[n] = cnt_q[n] + 4'd1;
                    end
                end
                GAP: begin
                    if (cnt_q[n] == GAP_LAST) begin
                        // An event on this very edge is absorbed into the restart.
                        pend_d[n] = 1'b0;
                        cnt_d[n]  = 4'd0;
                        st_d[n]   = ((pend_q[n] | ev[n]) & ~clr[n]) ? HIGH : IDLE;
                    end else begin
                        pend_d[n] = (pend_q[n] | ev[n]) & ~clr[n];
                        cnt_d[n]  = cnt_q[n] + 4'd1;
                    end
                end
                default: begin
                    st_d[n]   = IDLE;
                    cnt_d[n]  = 4'd0;
                    pend_d[n] = 1'b0;
                end
            endcase
        end
    end

    // Request outputs come straight from the state flops.
    always_comb begin
        ireq = 6'd0;
        for (int n = 1; n <= 6; n++) begin
            ireq[n] = (st_q[n] == HIGH);
        end
    end

endmodule

// File: tb/tb_irq_src_ctrl.sv
// Testbench for irq_src_ctrl: directed and random stimulus, a timing-based
// reference model and a per-cycle scoreboard.
module tb_irq_src_ctrl;

    localparam int PD = 8;
    localparam int PL = 4;
    localparam int GL = 4;

    logic       clk_asic = 1'b0;
    logic       rst_n    = 1'b0;
    logic       reg_we   = 1'b0;
    logic       reg_sel  = 1'b0;
    logic [7:0] reg_din  = 8'd0;
    logic [6:1] evt      = 6'd0;
    logic [7:0] reg_dout;
    logic [6:1] ireq;
    logic [6:1] imsk;

    irq_src_ctrl #(.PRESC_DIV(PD), .PULSE_LEN(PL), .GAP_LEN(GL)) dut (
        .clk_asic (clk_asic),
        .rst_n    (rst_n),
        .reg_we   (reg_we),
        .reg_sel  (reg_sel),
        .reg_din  (reg_din),
        .reg_dout (reg_dout),
        .evt      (evt),
        .ireq     (ireq),
        .imsk     (imsk)
    );

    always #5 clk_asic = ~clk_asic;

    typedef struct packed {
        logic [6:1] ireq;
        logic [6:1] imsk;
        logic [7:0] dout;
        int         t;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state: pulse start edges, pending flags, timer origin.
    int         ms   [1:6];
    bit         mpend[1:6];
    logic [7:0] mr  = 8'd0;
    int         mw  = 0;
    logic [6:1] mim = 6'd0;
    int         t   = 0;

    initial begin
        for (int n = 1; n <= 6; n++) begin
            ms[n]    = -1000;
            mpend[n] = 1'b0;
        end
    end

    // Apply one falling edge of inputs to the model and queue the expectation.
    task automatic model_edge(input logic rn, input logic we, input logic sel,
                              input logic [7:0] din, input logic [6:1] ev);
        logic [6:1] e;
        logic [6:1] clr;
        bit         e3;
        int         free_at;
        exp_t       x;
        if (!rn) begin
            for (int n = 1; n <= 6; n++) begin
                ms[n]    = -1000;
                mpend[n] = 1'b0;
            end
            mr  = 8'd0;
            mim = 6'd0;
            mw  = t;
        end else begin
            e3  = !(we && !sel) && (mr != 8'd0) && (t > mw) &&
                  (((t - mw) % (PD * (int'(mr) + 1))) == 0);
            e   = {ev[6:4], e3, ev[2:1]};
            clr = (we && sel) ? (mim & ~din[6:1]) : 6'd0;
            for (int n = 1; n <= 6; n++) begin
                free_at = ms[n] + PL + GL;
                if (t == free_at) begin
                    if ((mpend[n] || e[n]) && !clr[n]) ms[n] = t;
                    mpend[n] = 1'b0;
                end else if (t > free_at) begin
                    if (e[n]) ms[n] = t;
                    mpend[n] = 1'b0;
                end else begin
                    mpend[n] = (mpend[n] || e[n]) && !clr[n];
                end
            end
            if (we && !sel) begin
                mr = din;
                mw = t;
            end
            if (we && sel) mim = din[6:1];
        end
        for (int n = 1; n <= 6; n++) begin
            x.ireq[n] = (ms[n] <= t) && (t <= ms[n] + PL - 1);
        end
        x.imsk = mim;
        x.dout = sel ? {1'b0, mim, 1'b0} : mr;
        x.t    = t;
        sb.push_back(x);
        t++;
    endtask

    task automatic step(input logic rn, input logic we, input logic sel,
                        input logic [7:0] din, input logic [6:1] ev);
        @(posedge clk_asic);
        rst_n   = rn;
        reg_we  = we;
        reg_sel = sel;
        reg_din = din;
        evt     = ev;
        model_edge(rn, we, sel, din, ev);
    endtask

    task automatic idle(input int cycles, input logic sel);
        for (int i = 0; i < cycles; i++) step(1'b1, 1'b0, sel, 8'd0, 6'd0);
    endtask

    // Monitor: compare DUT outputs shortly after every falling edge.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk_asic);
            #2;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                checks++;
                if (ireq !== x.ireq) begin
                    failures++;
                    $display("FAIL ireq edge=%0d got=%b exp=%b", x.t, ireq, x.ireq);
                end
                checks++;
                if (imsk !== x.imsk) begin
                    failures++;
                    $display("FAIL imsk edge=%0d got=%b exp=%b", x.t, imsk, x.imsk);
                end
                checks++;
                if (reg_dout !== x.dout) begin
                    failures++;
                    $display("FAIL reg_dout edge=%0d got=%h exp=%h", x.t, reg_dout, x.dout);
                end
            end
        end
    end

    // Stimulus: directed scenarios first, then random traffic.
    initial begin
        logic       we;
        logic       sel;
        logic [7:0] din;
        logic [6:1] ev;

        // Reset held with every event strobe active.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 8'd0, 6'h3F);
        step(1'b1, 1'b0, 1'b0, 8'd0, 6'd0);
        step(1'b1, 1'b0, 1'b1, 8'd0, 6'd0);

        // Single level-5 event, then the coalescing case.
        step(1'b1, 1'b0, 1'b0, 8'd0, 6'b010000);
        idle(12, 1'b0);
        step(1'b1, 1'b0, 1'b0, 8'd0, 6'b010000);
        idle(1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 8'd0, 6'b010000);
        idle(3, 1'b0);
        step(1'b1, 1'b0, 1'b0, 8'd0, 6'b010000);
        idle(16, 1'b0);

        // Mask drop cancels the queued level-4 pulse.
        step(1'b1, 1'b1, 1'b1, 8'h7E, 6'd0);
        step(1'b1, 1'b0, 1'b1, 8'd0, 6'b001000);
        idle(1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 8'd0, 6'b001000);
        step(1'b1, 1'b1, 1'b1, 8'h6E, 6'd0);
        idle(14, 1'b1);

        // Periodic timer, then stop.
        step(1'b1, 1'b1, 1'b0, 8'd2, 6'd0);
        idle(80, 1'b0);
        step(1'b1, 1'b1, 1'b0, 8'd0, 6'd0);
        idle(40, 1'b0);

        // TIMER write colliding with an expiring tick.
        step(1'b1, 1'b1, 1'b0, 8'd1, 6'd0);
        idle(15, 1'b0);
        step(1'b1, 1'b1, 1'b0, 8'd5, 6'd0);
        idle(70, 1'b0);

        // Readback and ignored evt[3].
        step(1'b1, 1'b1, 1'b1, 8'hFF, 6'd0);
        step(1'b1, 1'b0, 1'b1, 8'd0, 6'd0);
        step(1'b1, 1'b1, 1'b0, 8'hA5, 6'd0);
        step(1'b1, 1'b0, 1'b0, 8'd0, 6'b000100);
        idle(3, 1'b0);
        step(1'b1, 1'b0, 1'b0, 8'd0, 6'b000100);
        step(1'b1, 1'b1, 1'b0, 8'd0, 6'b000100);
        idle(12, 1'b0);

        // Random traffic with occasional resets and register writes.
        for (int i = 0; i < 3000; i++) begin
            we  = ($urandom_range(0, 24) == 0);
            sel = $urandom_range(0, 1) == 1;
            din = 8'($urandom_range(0, 255));
            if (we && !sel) din = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 3));
            for (int b = 1; b <= 6; b++) ev[b] = ($urandom_range(0, 5) == 0);
            step(($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1, we, sel, din, ev);
        end
        idle(2, 1'b0);

        repeat (3) @(posedge clk_asic);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
